// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT result-stream frame collector.
package fft_pkg;

    localparam int DEF_N = 32;
    localparam int DEF_W = 16;

    typedef struct packed {
        logic signed [DEF_W-1:0] r;
        logic signed [DEF_W-1:0] i;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    // Reverses the low nbits of idx; supports frames up to 1024 points.
    function automatic logic [9:0] bitrev(input logic [9:0] idx, input int nbits);
        logic [9:0] r;
        r = '0;
        for (int b = 0; b < 10; b++) begin
            if (b < nbits) begin
                r[b] = idx[nbits-1-b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// N-entry complex sample store: one synchronous write port, one asynchronous read port.
module fft_frame_buf #(
    parameter int N  = 32,
    parameter int W  = 16,
    parameter int AW = $clog2(N)
) (
    input  logic            clk,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [2*W-1:0]  wr_data_i,
    input  logic [AW-1:0]   rd_addr_i,
    output logic [2*W-1:0]  rd_data_o
);

    logic [2*W-1:0] mem_q [N];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fft_frame_collector.sv
// Captures one N-sample FFT result frame after each res_ready rise and drains it
// in natural bin order over a valid/ready handshake.
module fft_frame_collector
    import fft_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int W      = DEF_W,
    parameter bit BITREV = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     res_ready,
    input  logic signed [W-1:0]      fft_r,
    input  logic signed [W-1:0]      fft_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [W-1:0]      out_r,
    output logic signed [W-1:0]      out_i,
    output logic [$clog2(N)-1:0]     out_idx,
    output logic                     frame_done,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int             AW   = $clog2(N);
    localparam logic [AW-1:0]  LAST = AW'(N - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   cap_cnt_q, cap_cnt_d;
    logic [AW-1:0]   rd_idx_q, rd_idx_d;
    logic            res_ready_q;
    logic            overrun_q, overrun_d;

    logic            rise;
    logic            hs;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [2*W-1:0]  rd_data;

    assign rise    = res_ready & ~res_ready_q;
    assign hs      = (state_q == DRAIN) & out_ready;
    assign wr_addr = BITREV ? AW'(bitrev(10'(cap_cnt_q), AW)) : cap_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cap_cnt_q   <= '0;
            rd_idx_q    <= '0;
            res_ready_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_cnt_q   <= cap_cnt_d;
            rd_idx_q    <= rd_idx_d;
            res_ready_q <= res_ready;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cap_cnt_d  = cap_cnt_q;
        rd_idx_d   = rd_idx_q;
        overrun_d  = overrun_q;
        wr_en      = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = CAPTURE;
                    cap_cnt_d = '0;
                end
            end
            CAPTURE: begin
                wr_en     = 1'b1;
                cap_cnt_d = cap_cnt_q + 1'b1;
                if (cap_cnt_q == LAST) begin
                    state_d   = DRAIN;
                    cap_cnt_d = '0;
                    rd_idx_d  = '0;
                end
            end
            DRAIN: begin
                if (hs) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (rd_idx_q == LAST) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                        rd_idx_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A busy rise outranks a same-cycle clear so no overrun is ever lost.
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (rise && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    fft_frame_buf #(
        .N  (N),
        .W  (W),
        .AW (AW)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i ({fft_r, fft_i}),
        .rd_addr_i (rd_idx_q),
        .rd_data_o (rd_data)
    );

    assign out_valid = (state_q == DRAIN);
    assign out_idx   = rd_idx_q;
    assign out_r     = rd_data[2*W-1:W];
    assign out_i     = rd_data[W-1:0];
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Drives natural- and bit-reversed-order collectors side by side and scoreboards every drained bin.
module tb_fft_frame_collector;
    import fft_pkg::*;

    localparam int N = 32;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic res_ready = 1'b0;
    logic out_ready = 1'b0;
    logic overrun_clr = 1'b0;
    logic signed [W-1:0] fft_r = '0;
    logic signed [W-1:0] fft_i = '0;

    logic v0, v1, fd0, fd1, ov0, ov1;
    logic signed [W-1:0] r0, r1, i0, i1;
    logic [4:0] idx0, idx1;

    cplx_t       frame [N];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int tests = 0;
    int fails = 0;
    int frames = 0;

    always #5 clk = ~clk;

    fft_frame_collector #(.N(N), .W(W), .BITREV(1'b0)) dut_nat (
        .clk(clk), .reset_n(reset_n), .res_ready(res_ready), .fft_r(fft_r), .fft_i(fft_i),
        .out_valid(v0), .out_ready(out_ready), .out_r(r0), .out_i(i0), .out_idx(idx0),
        .frame_done(fd0), .overrun(ov0), .overrun_clr(overrun_clr)
    );

    fft_frame_collector #(.N(N), .W(W), .BITREV(1'b1)) dut_rev (
        .clk(clk), .reset_n(reset_n), .res_ready(res_ready), .fft_r(fft_r), .fft_i(fft_i),
        .out_valid(v1), .out_ready(out_ready), .out_r(r1), .out_i(i1), .out_idx(idx1),
        .frame_done(fd1), .overrun(ov1), .overrun_clr(overrun_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rev5(input int x);
        int r;
        r = 0;
        for (int b = 0; b < 5; b++) begin
            if (x[b]) r = r | (1 << (4 - b));
        end
        return r;
    endfunction

    // Rise on res_ready, feed N samples; optionally reset after abort_after captures.
    task automatic capture(input int hold, input int abort_after);
        @(negedge clk);
        res_ready = 1'b1;
        for (int j = 0; j < N; j++) begin
            @(negedge clk);
            if (hold == 0) res_ready = 1'b0;
            if (j == abort_after) begin
                res_ready = 1'b0;
                reset_n = 1'b0;
                #1;
                check("abort_cap_valid_nat", 32'(v0), 32'd0);
                check("abort_cap_valid_rev", 32'(v1), 32'd0);
                @(negedge clk);
                reset_n = 1'b1;
                $display("[TB] capture aborted by reset after %0d samples", j);
                return;
            end
            if (j == N - 1) begin
                check("pre_drain_valid_nat", 32'(v0), 32'd0);
                check("pre_drain_valid_rev", 32'(v1), 32'd0);
            end
            fft_r = frame[j].r;
            fft_i = frame[j].i;
        end
        for (int b = 0; b < N; b++) begin
            q0.push_back(frame[b]);
            q1.push_back(frame[rev5(b)]);
        end
        @(negedge clk);
        check("first_valid_nat", 32'(v0), 32'd1);
        check("first_valid_rev", 32'(v1), 32'd1);
    endtask

    // Drain one frame; toggle alternates out_ready, rise_at injects a busy rise,
    // abort_at resets the design before that handshake.
    task automatic drain(input int toggle, input int rise_at, input int abort_at);
        int hs;
        int cyc;
        logic [31:0] e0, e1;
        hs = 0;
        cyc = 0;
        while (hs < N && cyc < 400) begin
            out_ready = (toggle != 0) ? ((cyc % 2) == 0) : 1'b1;
            if (rise_at >= 0) res_ready = (hs == rise_at);
            if (hs == abort_at) begin
                reset_n = 1'b0;
                #1;
                check("abort_drain_valid_nat", 32'(v0), 32'd0);
                check("abort_drain_valid_rev", 32'(v1), 32'd0);
                check("abort_drain_idx", 32'(idx0), 32'd0);
                q0.delete();
                q1.delete();
                out_ready = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                $display("[TB] drain aborted by reset at handshake %0d", hs);
                return;
            end
            #1;
            e0 = q0[0];
            e1 = q1[0];
            check("valid_nat", 32'(v0), 32'd1);
            check("valid_rev", 32'(v1), 32'd1);
            check("idx_nat", 32'(idx0), 32'(hs));
            check("idx_rev", 32'(idx1), 32'(hs));
            check("data_nat", {r0, i0}, e0);
            check("data_rev", {r1, i1}, e1);
            check("done_nat", 32'(fd0), 32'(out_ready && hs == N - 1));
            check("done_rev", 32'(fd1), 32'(out_ready && hs == N - 1));
            if (out_ready) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
                hs++;
            end
            cyc++;
            @(negedge clk);
        end
        if (rise_at >= 0) res_ready = 1'b0;
        check("handshake_count", 32'(hs), 32'(N));
        #1;
        check("valid_after_nat", 32'(v0), 32'd0);
        check("valid_after_rev", 32'(v1), 32'd0);
        frames++;
        $display("[TB] frame %0d drained: %0d handshakes in %0d cycles", frames, hs, cyc);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(v0 | v1), 32'd0);
        check("rst_idx", 32'({idx0, idx1}), 32'd0);
        check("rst_done", 32'(fd0 | fd1), 32'd0);
        check("rst_overrun", 32'(ov0 | ov1), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Ramp (j, -j)
        for (int j = 0; j < N; j++) begin
            frame[j].r = 16'(j);
            frame[j].i = 16'(-j);
        end
        capture(0, -1);
        drain(0, -1, -1);

        // Square wave
        for (int j = 0; j < N; j++) begin
            frame[j].r = (((j / 8) % 2) != 0) ? 16'hff81 : 16'h007f;
            frame[j].i = 16'h0000;
        end
        capture(0, -1);
        drain(0, -1, -1);

        // Backpressure with random data
        for (int j = 0; j < N; j++) begin
            frame[j].r = 16'($urandom);
            frame[j].i = 16'($urandom);
        end
        capture(0, -1);
        drain(1, -1, -1);

        // Overrun during drain, then clear
        for (int j = 0; j < N; j++) begin
            frame[j].r = 16'(j * 3 + 1);
            frame[j].i = 16'(100 - j);
        end
        capture(0, -1);
        check("overrun_before", 32'(ov0 | ov1), 32'd0);
        drain(0, 5, -1);
        check("overrun_set_nat", 32'(ov0), 32'd1);
        check("overrun_set_rev", 32'(ov1), 32'd1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("overrun_cleared", 32'(ov0 | ov1), 32'd0);

        // Rise on the final handshake edge is busy: no new frame, overrun set
        capture(0, -1);
        drain(0, N - 1, -1);
        repeat (40) @(negedge clk);
        check("last_edge_rise_no_frame", 32'(v0 | v1), 32'd0);
        check("last_edge_rise_overrun", 32'(ov0 & ov1), 32'd1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;

        // Reset after 10 captures, then a clean frame
        capture(0, 10);
        check("post_abort_valid", 32'(v0 | v1), 32'd0);
        repeat (40) @(negedge clk);
        check("partial_never_emitted", 32'(v0 | v1), 32'd0);
        for (int j = 0; j < N; j++) begin
            frame[j].r = 16'($urandom);
            frame[j].i = 16'($urandom);
        end
        capture(0, -1);
        drain(0, -1, -1);

        // Reset mid-drain, then a clean frame
        capture(0, -1);
        drain(0, -1, 7);
        capture(0, -1);
        drain(1, -1, -1);

        // Level hold: res_ready high for over 100 cycles
        for (int j = 0; j < N; j++) begin
            frame[j].r = 16'(-(j * 7));
            frame[j].i = 16'(j << 4);
        end
        capture(1, -1);
        drain(0, -1, -1);
        repeat (40) @(negedge clk);
        check("hold_single_frame", 32'(v0 | v1), 32'd0);
        check("hold_no_overrun", 32'(ov0 | ov1), 32'd0);
        res_ready = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
